kanagawa_pipelined_link_receiver: RTL and testbench



---
 rtl/kanagawa_pipelined_link_receiver.sv | 128 ++++++++++++
 tb/tb_kanagawa_pipelined_link_receiver.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/kanagawa_pipelined_link_receiver.sv
// Far-end receiver of a credit-flow-controlled pipelined link: FWFT capture buffer plus delayed credit return.
// Optional sticky overflow detection enabled by defining KANAGAWA_LINK_RX_OVERFLOW_CHECK_EN.
module kanagawa_pipelined_link_receiver #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned CAPACITY     = 8,
  parameter int unsigned CREDIT_DELAY = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  output logic [WIDTH-1:0]               out_data,
  input  logic                           out_ready,
  output logic                           credit_return,
  output logic [$clog2(CAPACITY+1)-1:0]  occupancy,
  output logic                           overflow
);

  localparam int unsigned OCC_W = $clog2(CAPACITY + 1);
  localparam int unsigned PTR_W = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;

  logic [WIDTH-1:0] mem [CAPACITY];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_next, rd_ptr_next;
  logic [OCC_W-1:0] occ, occ_next;
  logic             full, pop, push_acc, drop;

  assign full     = (occ == OCC_W'(CAPACITY));
  assign pop      = out_valid && out_ready;
  // A full buffer still accepts a beat when the head leaves in the same cycle.
  assign push_acc = in_valid && (!full || pop);
  assign drop     = in_valid && full && !pop;

  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    occ_next    = occ;
    if (push_acc) begin
      wr_ptr_next = (wr_ptr == PTR_W'(CAPACITY - 1)) ? '0 : wr_ptr + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr == PTR_W'(CAPACITY - 1)) ? '0 : rd_ptr + PTR_W'(1);
    end
    if (push_acc && !pop) begin
      occ_next = occ + OCC_W'(1);
    end else if (pop && !push_acc) begin
      occ_next = occ - OCC_W'(1);
    end
  end

  // Pointer, count and registered valid state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      out_valid <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      occ       <= occ_next;
      out_valid <= (occ_next != '0);
    end
  end

  // Storage is cleared on reset so the head output reads zero while empty after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(CAPACITY); i++) begin
        mem[i] <= '0;
      end
    end else if (push_acc) begin
      mem[wr_ptr] <= in_data;
    end
  end

  assign out_data  = mem[rd_ptr];
  assign occupancy = occ;

  // Credit return chain: one bit per pop, never merged, flushed by reset.
  generate
    if (CREDIT_DELAY == 0) begin : g_credit_direct
      logic credit_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          credit_q <= 1'b0;
        end else begin
          credit_q <= pop;
        end
      end
      assign credit_return = credit_q;
    end else begin : g_credit_chain
      logic [CREDIT_DELAY:0] credit_pipe;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          credit_pipe <= '0;
        end else begin
          credit_pipe <= {credit_pipe[CREDIT_DELAY-1:0], pop};
        end
      end
      assign credit_return = credit_pipe[CREDIT_DELAY];
    end
  endgenerate

`ifdef KANAGAWA_LINK_RX_OVERFLOW_CHECK_EN
  logic overflow_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end
  assign overflow = overflow_q;

  always @(posedge clk) begin
    if (!rst) begin
      assert (!drop) else $error("%m: beat dropped, push into full buffer without pop");
    end
  end
`else
  assign overflow = 1'b0;
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_kanagawa_pipelined_link_receiver.sv
// Directed bench for kanagawa_pipelined_link_receiver with a data scoreboard queue.
module tb_kanagawa_pipelined_link_receiver;

  localparam int unsigned W   = 32;
  localparam int unsigned CAP = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, out_ready, out_valid, credit_return, overflow;
  logic [W-1:0] in_data, out_data;
  logic [3:0]   occupancy;
  logic         in_valid3, out_ready3, out_valid3, credit_return3, overflow3;
  logic [W-1:0] in_data3, out_data3;
  logic [3:0]   occupancy3;

  always #5 clk = ~clk;

  kanagawa_pipelined_link_receiver #(.WIDTH(W), .CAPACITY(CAP), .CREDIT_DELAY(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .credit_return(credit_return), .occupancy(occupancy), .overflow(overflow));

  kanagawa_pipelined_link_receiver #(.WIDTH(W), .CAPACITY(CAP), .CREDIT_DELAY(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_data(in_data3),
    .out_valid(out_valid3), .out_data(out_data3), .out_ready(out_ready3),
    .credit_return(credit_return3), .occupancy(occupancy3), .overflow(overflow3));

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sb[$];
  logic ovf_exp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle on the CREDIT_DELAY=0 instance, checked against the scoreboard.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input string tag);
    logic p;
    logic [W-1:0] e;
    chk({tag, "/valid"}, 32'(out_valid), 32'(sb.size() != 0));
    p = (sb.size() != 0) && r;
    if (p) begin
      e = sb.pop_front();
      chk({tag, "/data"}, out_data, e);
    end
    in_valid = v; in_data = d; out_ready = r;
    @(posedge clk); #1;
    if (v) begin
      if (sb.size() < CAP) sb.push_back(d);
      else begin
`ifdef KANAGAWA_LINK_RX_OVERFLOW_CHECK_EN
        ovf_exp = 1'b1;
`endif
      end
    end
    chk({tag, "/occ"}, 32'(occupancy), 32'(sb.size()));
    chk({tag, "/credit"}, 32'(credit_return), 32'(p));
    chk({tag, "/ovf"}, 32'(overflow), 32'(ovf_exp));
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic cyc3(input logic v, input logic [W-1:0] d, input logic r);
    in_valid3 = v; in_data3 = d; out_ready3 = r;
    @(posedge clk); #1;
    in_valid3 = 1'b0; out_ready3 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b0;
    @(posedge clk); #1;
    chk("rst/valid", 32'(out_valid), 32'd0);
    chk("rst/data", out_data, 32'd0);
    chk("rst/credit", 32'(credit_return), 32'd0);
    chk("rst/occ", 32'(occupancy), 32'd0);
    chk("rst/ovf", 32'(overflow), 32'd0);
    rst = 1'b0;

    // Single beat with fall-through latency and credit one cycle after the pop.
    cycle(1'b0, '0, 1'b1, "idle");
    cycle(1'b1, 32'hA5, 1'b1, "single_push");
    cycle(1'b0, '0, 1'b1, "single_pop");
    cycle(1'b0, '0, 1'b0, "single_after");

    // Fill to capacity, then drain in order with back-to-back credits.
    for (int i = 0; i < int'(CAP); i++) cycle(1'b1, 32'(i), 1'b0, "fill");
    for (int i = 0; i < int'(CAP); i++) cycle(1'b0, '0, 1'b1, "drain");
    cycle(1'b0, '0, 1'b0, "drained");

    // Full with simultaneous push and pop across pointer wrap.
    for (int i = 0; i < int'(CAP); i++) cycle(1'b1, 32'(100 + i), 1'b0, "refill");
    for (int i = 0; i < 20; i++) cycle(1'b1, 32'(200 + i), 1'b1, "full_pp");

    // Push into full buffer without pop is dropped.
    cycle(1'b1, 32'hFF, 1'b0, "drop");
    cycle(1'b0, '0, 1'b0, "drop_hold");
    for (int i = 0; i < int'(CAP); i++) cycle(1'b0, '0, 1'b1, "drain2");
    cycle(1'b0, '0, 1'b0, "drained2");

    // CREDIT_DELAY=3: pops at relative cycles 0,1,3 give credits at 4,5,7.
    for (int i = 0; i < 3; i++) cyc3(1'b1, 32'(300 + i), 1'b0);
    for (int k = 0; k < 10; k++) begin
      chk("dly3/credit", 32'(credit_return3), 32'((k == 4) || (k == 5) || (k == 7)));
      cyc3(1'b0, '0, (k == 0) || (k == 1) || (k == 3));
    end
    chk("dly3/occ", 32'(occupancy3), 32'd0);

    // Asynchronous reset mid-cycle with entries stored and credits in flight.
    for (int i = 0; i < 5; i++) cyc3(1'b1, 32'(400 + i), 1'b0);
    chk("pre_rst/data", out_data3, 32'd400);
    cyc3(1'b0, '0, 1'b1);
    cyc3(1'b0, '0, 1'b1);
    chk("pre_rst/occ", 32'(occupancy3), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst/valid", 32'(out_valid3), 32'd0);
    chk("arst/data", out_data3, 32'd0);
    chk("arst/occ", 32'(occupancy3), 32'd0);
    chk("arst/credit", 32'(credit_return3), 32'd0);
    chk("arst/ovf", 32'(overflow3), 32'd0);
    sb.delete();
    ovf_exp = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("arst/ovf_main", 32'(overflow), 32'd0);
    for (int k = 0; k < 6; k++) begin
      chk("post_rst/credit", 32'(credit_return3), 32'd0);
      cyc3(1'b0, '0, 1'b0);
    end
    chk("post_rst/valid", 32'(out_valid3), 32'd0);
    cyc3(1'b1, 32'h5A, 1'b1);
    chk("post_push/valid", 32'(out_valid3), 32'd1);
    chk("post_push/data", out_data3, 32'h5A);
    chk("post_push/occ", 32'(occupancy3), 32'd1);
    cycle(1'b1, 32'h77, 1'b0, "main_after_rst");
    cycle(1'b0, '0, 1'b1, "main_after_rst_pop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
